// File: rtl/rf_bank_read_scheduler.sv
// Per-bank read request queues between dispatch and the 4-bank register file.
// One read per bank per cycle; tags are delayed one cycle to line up with RF data.
module rf_bank_read_scheduler #(
  parameter int FIFO_DEPTH = 8,
  parameter int ROW_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Disp_Valid,
  input  logic [2:0]       Disp_WarpID,
  input  logic [1:0]       Disp_EntryNum,
  input  logic [5:0]       IB_Src1_Out,
  input  logic [5:0]       IB_Src2_Out,
  input  logic [3:0]       RAU_Src1_PhyReg,
  input  logic [3:0]       RAU_Src2_PhyReg,
  input  logic [3:0]       RF_Wr_Bank_Busy,
  output logic [3:0]       RF_Rd_En,
  output logic [ROW_W-1:0] RF_Rd_Addr_Bank0,
  output logic [ROW_W-1:0] RF_Rd_Addr_Bank1,
  output logic [ROW_W-1:0] RF_Rd_Addr_Bank2,
  output logic [ROW_W-1:0] RF_Rd_Addr_Bank3,
  output logic [3:0]       RF_Dout_Valid,
  output logic [1:0]       RF_Bank0_EntryNum_OC,
  output logic [1:0]       RF_Bank1_EntryNum_OC,
  output logic [1:0]       RF_Bank2_EntryNum_OC,
  output logic [1:0]       RF_Bank3_EntryNum_OC,
  output logic [3:0]       RF_SrcNum_OC,
  output logic             Sched_Overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [1:0]       entry;
    logic             src;
  } rec_t;

  logic       push1;
  logic       push2;
  logic [1:0] bk1;
  logic [1:0] bk2;
  rec_t       rec1;
  rec_t       rec2;

  // $8 and $16 come from RAU, so they never generate a bank read
  assign push1 = Disp_Valid & IB_Src1_Out[5]
               & (IB_Src1_Out[4:0] != 5'd8)
               & (IB_Src1_Out[4:0] != 5'd16);
  assign push2 = Disp_Valid & IB_Src2_Out[5]
               & (IB_Src2_Out[4:0] != 5'd8)
               & (IB_Src2_Out[4:0] != 5'd16);

  assign bk1 = RAU_Src1_PhyReg[1:0];
  assign bk2 = RAU_Src2_PhyReg[1:0];

  assign rec1 = '{row:   {Disp_WarpID, RAU_Src1_PhyReg[3:2]},
                  entry: Disp_EntryNum,
                  src:   1'b0};
  assign rec2 = '{row:   {Disp_WarpID, RAU_Src2_PhyReg[3:2]},
                  entry: Disp_EntryNum,
                  src:   1'b1};

  logic [3:0]            pop;
  logic [3:0]            ovf_set;
  logic [3:0][ROW_W-1:0] head_row;
  logic [3:0][1:0]       head_ent;
  logic [3:0]            head_src;

  for (genvar g = 0; g < 4; g++) begin : g_bank
    rec_t          mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] space;
    logic          hit1;
    logic          hit2;
    logic          acc1;
    logic          acc2;
    logic [PW-1:0] wr2_ptr;
    rec_t          head;

    assign hit1  = push1 && (bk1 == 2'(g));
    assign hit2  = push2 && (bk2 == 2'(g));
    assign space = CW'(FIFO_DEPTH) - cnt;
    assign acc1  = hit1 && (space != '0);
    assign acc2  = hit2 && (hit1 ? (space >= CW'(2))
                                 : (space != '0));

    assign ovf_set[g] = (hit1 && !acc1) || (hit2 && !acc2);

    // src2 lands behind src1 when both target this bank
    assign wr2_ptr = acc1 ? wr_ptr + PW'(1) : wr_ptr;

    assign head = mem[rd_ptr];
    assign pop[g] = (cnt != '0) && !RF_Wr_Bank_Busy[g];

    assign head_row[g] = head.row;
    assign head_ent[g] = head.entry;
    assign head_src[g] = head.src;

    always_ff @(posedge clk) begin
      if (acc1) mem[wr_ptr] <= rec1;
      if (acc2) mem[wr2_ptr] <= rec2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        wr_ptr <= wr_ptr + PW'(acc1) + PW'(acc2);
        rd_ptr <= rd_ptr + PW'(pop[g]);
        cnt    <= cnt + CW'(acc1) + CW'(acc2)
                - CW'(pop[g]);
      end
    end
  end

  assign RF_Rd_En = pop;

  assign RF_Rd_Addr_Bank0 = pop[0] ? head_row[0] : '0;
  assign RF_Rd_Addr_Bank1 = pop[1] ? head_row[1] : '0;
  assign RF_Rd_Addr_Bank2 = pop[2] ? head_row[2] : '0;
  assign RF_Rd_Addr_Bank3 = pop[3] ? head_row[3] : '0;

  logic [3:0][1:0] tag_ent;
  logic [3:0]      tag_src;
  logic [3:0]      tag_vld;

  // Tags ride one cycle behind the read to meet the RF data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      tag_ent <= '0;
      tag_src <= '0;
    end else begin
      tag_vld <= pop;
      for (int b = 0; b < 4; b++) begin
        tag_ent[b] <= pop[b] ? head_ent[b] : 2'b00;
        tag_src[b] <= pop[b] & head_src[b];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Sched_Overflow <= 1'b0;
    else if (|ovf_set) Sched_Overflow <= 1'b1;
  end

  assign RF_Dout_Valid        = tag_vld;
  assign RF_Bank0_EntryNum_OC = tag_ent[0];
  assign RF_Bank1_EntryNum_OC = tag_ent[1];
  assign RF_Bank2_EntryNum_OC = tag_ent[2];
  assign RF_Bank3_EntryNum_OC = tag_ent[3];
  assign RF_SrcNum_OC         = tag_src;

endmodule

// File: tb/tb_rf_bank_read_scheduler.sv
// Scoreboard bench for rf_bank_read_scheduler: stimulus queues expected
// per-bank reads, a negedge monitor checks reads and tag returns.
module tb_rf_bank_read_scheduler;

  typedef struct packed {
    logic [4:0] row;
    logic [1:0] entry;
    logic       src;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Disp_Valid;
  logic [2:0] Disp_WarpID;
  logic [1:0] Disp_EntryNum;
  logic [5:0] IB_Src1_Out;
  logic [5:0] IB_Src2_Out;
  logic [3:0] RAU_Src1_PhyReg;
  logic [3:0] RAU_Src2_PhyReg;
  logic [3:0] RF_Wr_Bank_Busy;
  logic [3:0] RF_Rd_En;
  logic [4:0] RF_Rd_Addr_Bank0;
  logic [4:0] RF_Rd_Addr_Bank1;
  logic [4:0] RF_Rd_Addr_Bank2;
  logic [4:0] RF_Rd_Addr_Bank3;
  logic [3:0] RF_Dout_Valid;
  logic [1:0] RF_Bank0_EntryNum_OC;
  logic [1:0] RF_Bank1_EntryNum_OC;
  logic [1:0] RF_Bank2_EntryNum_OC;
  logic [1:0] RF_Bank3_EntryNum_OC;
  logic [3:0] RF_SrcNum_OC;
  logic       Sched_Overflow;

  rf_bank_read_scheduler dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .Disp_Valid           (Disp_Valid),
    .Disp_WarpID          (Disp_WarpID),
    .Disp_EntryNum        (Disp_EntryNum),
    .IB_Src1_Out          (IB_Src1_Out),
    .IB_Src2_Out          (IB_Src2_Out),
    .RAU_Src1_PhyReg      (RAU_Src1_PhyReg),
    .RAU_Src2_PhyReg      (RAU_Src2_PhyReg),
    .RF_Wr_Bank_Busy      (RF_Wr_Bank_Busy),
    .RF_Rd_En             (RF_Rd_En),
    .RF_Rd_Addr_Bank0     (RF_Rd_Addr_Bank0),
    .RF_Rd_Addr_Bank1     (RF_Rd_Addr_Bank1),
    .RF_Rd_Addr_Bank2     (RF_Rd_Addr_Bank2),
    .RF_Rd_Addr_Bank3     (RF_Rd_Addr_Bank3),
    .RF_Dout_Valid        (RF_Dout_Valid),
    .RF_Bank0_EntryNum_OC (RF_Bank0_EntryNum_OC),
    .RF_Bank1_EntryNum_OC (RF_Bank1_EntryNum_OC),
    .RF_Bank2_EntryNum_OC (RF_Bank2_EntryNum_OC),
    .RF_Bank3_EntryNum_OC (RF_Bank3_EntryNum_OC),
    .RF_SrcNum_OC         (RF_SrcNum_OC),
    .Sched_Overflow       (Sched_Overflow)
  );

  always #5 clk = ~clk;

  logic [4:0] addr_w [4];
  logic [1:0] ent_w  [4];
  assign addr_w[0] = RF_Rd_Addr_Bank0;
  assign addr_w[1] = RF_Rd_Addr_Bank1;
  assign addr_w[2] = RF_Rd_Addr_Bank2;
  assign addr_w[3] = RF_Rd_Addr_Bank3;
  assign ent_w[0]  = RF_Bank0_EntryNum_OC;
  assign ent_w[1]  = RF_Bank1_EntryNum_OC;
  assign ent_w[2]  = RF_Bank2_EntryNum_OC;
  assign ent_w[3]  = RF_Bank3_EntryNum_OC;

  int   nvec = 0;
  int   nerr = 0;
  rec_t rdq [4][$];
  logic exp_ovf = 1'b0;
  logic [3:0] pend = '0;
  rec_t pend_tag [4];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: expected read when model queue non-empty and bank free
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        logic exp_en;
        check($sformatf("dout_valid[%0d]", b),
              32'(RF_Dout_Valid[b]), 32'(pend[b]));
        if (pend[b] && RF_Dout_Valid[b]) begin
          check($sformatf("entry[%0d]", b),
                32'(ent_w[b]), 32'(pend_tag[b].entry));
          check($sformatf("srcnum[%0d]", b),
                32'(RF_SrcNum_OC[b]), 32'(pend_tag[b].src));
        end
        exp_en = (rdq[b].size() != 0) && !RF_Wr_Bank_Busy[b];
        check($sformatf("rd_en[%0d]", b),
              32'(RF_Rd_En[b]), 32'(exp_en));
        if (exp_en && RF_Rd_En[b]) begin
          check($sformatf("rd_addr[%0d]", b),
                32'(addr_w[b]), 32'(rdq[b][0].row));
          pend_tag[b] = rdq[b].pop_front();
          pend[b] = 1'b1;
        end else begin
          pend[b] = 1'b0;
        end
      end
    end
  end

  task automatic model_push(input logic [2:0] w, input logic [1:0] e,
                            input logic [5:0] s, input logic [3:0] p,
                            input logic sn);
    rec_t r;
    if (s[5] && s[4:0] != 5'd8 && s[4:0] != 5'd16) begin
      r.row   = {w, p[3:2]};
      r.entry = e;
      r.src   = sn;
      if (rdq[p[1:0]].size() >= 8) exp_ovf = 1'b1;
      else rdq[p[1:0]].push_back(r);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1
  task automatic dispatch(input logic [2:0] w, input logic [1:0] e,
                          input logic [5:0] s1, input logic [3:0] p1,
                          input logic [5:0] s2, input logic [3:0] p2);
    Disp_Valid      = 1'b1;
    Disp_WarpID     = w;
    Disp_EntryNum   = e;
    IB_Src1_Out     = s1;
    IB_Src2_Out     = s2;
    RAU_Src1_PhyReg = p1;
    RAU_Src2_PhyReg = p2;
    @(posedge clk);
    #1;
    model_push(w, e, s1, p1, 1'b0);
    model_push(w, e, s2, p2, 1'b1);
    Disp_Valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string nm);
    check({nm, " rd_en"}, 32'(RF_Rd_En), 32'h0);
    check({nm, " dout_valid"}, 32'(RF_Dout_Valid), 32'h0);
    check({nm, " addrs"}, {RF_Rd_Addr_Bank0, RF_Rd_Addr_Bank1,
          RF_Rd_Addr_Bank2, RF_Rd_Addr_Bank3}, 32'h0);
    check({nm, " tags"}, {RF_Bank0_EntryNum_OC, RF_Bank1_EntryNum_OC,
          RF_Bank2_EntryNum_OC, RF_Bank3_EntryNum_OC, RF_SrcNum_OC},
          32'h0);
    check({nm, " overflow"}, 32'(Sched_Overflow), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    Disp_Valid      = 1'b0;
    Disp_WarpID     = '0;
    Disp_EntryNum   = '0;
    IB_Src1_Out     = '0;
    IB_Src2_Out     = '0;
    RAU_Src1_PhyReg = '0;
    RAU_Src2_PhyReg = '0;
    RF_Wr_Bank_Busy = '0;
    step(2);
    check_zero("reset");
    rst_n = 1'b1;
    step(1);

    // 1: warp2 entry1, r3->phy5 (bank1), r4->phy6 (bank2)
    dispatch(3'd2, 2'd1, 6'h23, 4'd5, 6'h24, 4'd6);
    check("t1 rd_en", 32'(RF_Rd_En), 32'h6);
    check("t1 addr1", 32'(RF_Rd_Addr_Bank1), 32'h09);
    check("t1 addr2", 32'(RF_Rd_Addr_Bank2), 32'h09);
    step(1);
    check("t1 dout_valid", 32'(RF_Dout_Valid), 32'h6);
    check("t1 ent1", 32'(RF_Bank1_EntryNum_OC), 32'h1);
    check("t1 ent2", 32'(RF_Bank2_EntryNum_OC), 32'h1);
    check("t1 srcnum", 32'(RF_SrcNum_OC), 32'h4);
    step(1);

    // 2: r8 / r16 never scheduled
    dispatch(3'd1, 2'd2, 6'h28, 4'd1, 6'h30, 4'd2);
    check("t2 rd_en", 32'(RF_Rd_En), 32'h0);
    step(1);
    check("t2 dout_valid", 32'(RF_Dout_Valid), 32'h0);

    // 3: phy4 and phy8 both bank0, src1 first
    dispatch(3'd3, 2'd2, 6'h21, 4'd4, 6'h22, 4'd8);
    check("t3 addr first", 32'(RF_Rd_Addr_Bank0), 32'h0d);
    step(1);
    check("t3 addr second", 32'(RF_Rd_Addr_Bank0), 32'h0e);
    check("t3 src first", 32'(RF_SrcNum_OC[0]), 32'h0);
    step(1);
    check("t3 src second", 32'(RF_SrcNum_OC[0]), 32'h1);
    step(2);

    // 4: bank0 write-blocked for 3 cycles, bank1 unaffected
    RF_Wr_Bank_Busy = 4'b0001;
    dispatch(3'd1, 2'd0, 6'h25, 4'd0, 6'h26, 4'd1);
    check("t4 cyc1", 32'(RF_Rd_En), 32'h2);
    step(1);
    check("t4 cyc2", 32'(RF_Rd_En), 32'h0);
    step(1);
    check("t4 cyc3", 32'(RF_Rd_En), 32'h0);
    RF_Wr_Bank_Busy = 4'b0000;
    #1;
    check("t4 release", 32'(RF_Rd_En), 32'h1);
    step(3);

    // 5: fill bank3 while blocked, then overflow
    RF_Wr_Bank_Busy = 4'b1000;
    dispatch(3'd0, 2'd0, 6'h21, 4'd3,  6'h22, 4'd7);
    dispatch(3'd1, 2'd1, 6'h21, 4'd11, 6'h22, 4'd15);
    dispatch(3'd2, 2'd2, 6'h21, 4'd3,  6'h22, 4'd7);
    dispatch(3'd3, 2'd3, 6'h21, 4'd11, 6'h22, 4'd15);
    check("t5 no ovf at 8", 32'(Sched_Overflow), 32'h0);
    dispatch(3'd4, 2'd0, 6'h21, 4'd3, 6'h00, 4'd0);
    check("t5 ovf", 32'(Sched_Overflow), 32'(exp_ovf));
    RF_Wr_Bank_Busy = 4'b0000;
    step(10);
    dispatch(3'd5, 2'd1, 6'h21, 4'd7, 6'h22, 4'd11);
    step(4);
    check("t5 ovf sticky", 32'(Sched_Overflow), 32'h1);

    // 6: reset with bank1 backlog and a bank2 read in flight
    RF_Wr_Bank_Busy = 4'b0010;
    dispatch(3'd6, 2'd2, 6'h21, 4'd1, 6'h22, 4'd5);
    dispatch(3'd7, 2'd3, 6'h21, 4'd9, 6'h22, 4'd2);
    @(posedge clk);
    #2;
    check("t6 in flight", 32'(RF_Dout_Valid), 32'h4);
    rst_n = 1'b0;
    for (int b = 0; b < 4; b++) rdq[b].delete();
    exp_ovf = 1'b0;
    #1;
    check_zero("t6 reset");
    RF_Wr_Bank_Busy = 4'b0000;
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("t6 post dout_valid", 32'(RF_Dout_Valid), 32'h0);
      check("t6 post rd_en", 32'(RF_Rd_En), 32'h0);
    end

    // Drain, bounded
    for (int i = 0; i < 50; i++) begin
      if (rdq[0].size() + rdq[1].size()
          + rdq[2].size() + rdq[3].size() == 0) break;
      step(1);
    end
    step(2);
    for (int b = 0; b < 4; b++)
      check($sformatf("drain bank%0d", b), 32'(rdq[b].size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
